// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings for the bitwise logic unit.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

endpackage

// File: rtl/logic_core.sv
// Combinational bitwise function selected by opcode, with zero and parity flags.
module logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             parity
);

  always_comb begin
    res = a;
    unique case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOR:   res = ~(a | b);
      OP_NAND:  res = ~(a & b);
      OP_XNOR:  res = ~(a ^ b);
      OP_NOTA:  res = ~a;
      OP_PASSA: res = a;
      default:  res = a;
    endcase
    zero   = (res == '0);
    parity = ^res;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage elastic bitwise logic unit: S1 captures operands, S2 holds the result.
module logic_unit_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OP_W  = alu_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             parity
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] core_res;
  logic             core_zero, core_parity;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .res    (core_res),
    .zero   (core_zero),
    .parity (core_parity)
  );

  // in_ready depends only on the valid bits and out_ready, never on in_valid.
  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    in_ready = s1_adv;
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_op_d = s1_op_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d  = a;
        s1_b_d  = b;
        s1_op_d = op;
      end
    end
  end

  // Result registers keep their last value across bubbles; only s2_v clears.
  always_comb begin
    s2_v_d   = s2_v_q;
    c_d      = c_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        c_d      = core_res;
        zero_d   = core_zero;
        parity_d = core_parity;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_op_q  <= '0;
      s2_v_q   <= 1'b0;
      c_q      <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_op_q  <= s1_op_d;
      s2_v_q   <= s2_v_d;
      c_q      <= c_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign out_valid = s2_v_q;
  assign c         = c_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Drives three widths (64, 8, 1) in lockstep and checks them against a queue-based model.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a, b;
  logic [2:0]  op;

  logic        rdy [3];
  logic        ovld[3];
  logic [63:0] cx  [3];
  logic        z   [3];
  logic        p   [3];

  logic [7:0] c8;
  logic [0:0] c1;

  int W[3] = '{64, 8, 1};

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .op(op), .out_valid(ovld[0]), .out_ready(out_ready),
    .c(cx[0]), .zero(z[0]), .parity(p[0]));

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(ovld[1]), .out_ready(out_ready),
    .c(c8), .zero(z[1]), .parity(p[1]));

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a[0:0]), .b(b[0:0]), .op(op), .out_valid(ovld[2]), .out_ready(out_ready),
    .c(c1), .zero(z[2]), .parity(p[2]));

  assign cx[1] = {56'b0, c8};
  assign cx[2] = {63'b0, c1};

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    int          pos;   // 1 = operand stage, 2 = result stage
  } item_t;

  item_t       pipe[$];
  logic [63:0] last_c;
  bit          after_rst;

  int checks = 0;
  int errors = 0;
  int n_acc, n_out, n_rdy_low;

  function automatic logic [63:0] mask(int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] lfun(logic [2:0] o, logic [63:0] x, logic [63:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~(x & y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check ready, update model at posedge, check outputs at next negedge.
  task automatic step(input logic v, input logic [63:0] ta, input logic [63:0] tb_,
                      input logic [2:0] top, input logic ordy, input logic r);
    logic  exp_rdy, acc, ev;
    logic [63:0] ec;
    item_t it;
    in_valid = v; a = ta; b = tb_; op = top; out_ready = ordy; rst = r;
    #1;
    exp_rdy = (pipe.size() < 2) || ordy;
    for (int k = 0; k < 3; k++) chk($sformatf("in_ready_w%0d", W[k]), {63'b0, rdy[k]}, {63'b0, exp_rdy});
    acc = v && exp_rdy && !r;
    if (v && rdy[0] && !r) n_acc++;
    if (!rdy[0]) n_rdy_low++;
    if (!r && ovld[0] && ordy) n_out++;
    @(posedge clk);
    if (r) begin
      pipe.delete();
      last_c    = '0;
      after_rst = 1'b1;
    end else begin
      if (pipe.size() > 0 && pipe[0].pos == 2 && ordy) void'(pipe.pop_front());
      if (pipe.size() > 0 && pipe[0].pos == 1) begin
        pipe[0].pos = 2;
        last_c      = lfun(pipe[0].op, pipe[0].a, pipe[0].b);
        after_rst   = 1'b0;
      end
      if (acc) begin
        it.a = ta; it.b = tb_; it.op = top; it.pos = 1;
        pipe.push_back(it);
      end
    end
    @(negedge clk);
    ev = (pipe.size() > 0) && (pipe[0].pos == 2);
    for (int k = 0; k < 3; k++) begin
      ec = last_c & mask(W[k]);
      chk($sformatf("out_valid_w%0d", W[k]), {63'b0, ovld[k]}, {63'b0, ev});
      chk($sformatf("c_w%0d", W[k]), cx[k], ec);
      chk($sformatf("zero_w%0d", W[k]), {63'b0, z[k]}, {63'b0, (!after_rst && ec == 64'd0)});
      chk($sformatf("parity_w%0d", W[k]), {63'b0, p[k]}, {63'b0, (!after_rst && ^ec)});
    end
  endtask

  // Single op with out_ready high; result is checked against a literal two cycles after transfer.
  task automatic directed(input string name, input logic [2:0] top, input logic [63:0] ta,
                          input logic [63:0] tb_, input logic [63:0] exp, input int ez, input int ep);
    step(1'b1, ta, tb_, top, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);
    chk({name, "_valid"}, {63'b0, ovld[0]}, 64'd1);
    chk({name, "_c64"}, cx[0], exp);
    chk({name, "_c8"}, cx[1], exp & 64'hFF);
    chk({name, "_c1"}, cx[2], exp & 64'h1);
    if (ez >= 0) chk({name, "_zero64"}, {63'b0, z[0]}, 64'(ez));
    if (ep >= 0) chk({name, "_parity64"}, {63'b0, p[0]}, 64'(ep));
    step(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);
  endtask

  localparam logic [63:0] SA = 64'h123456789ABCDEF0;
  localparam logic [63:0] SB = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] SX = 64'hDEAABEEECAAEBEBE;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    last_c = '0; after_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b1);
    chk("reset_out_valid", {63'b0, ovld[0]}, 64'd0);
    chk("reset_c", cx[0], 64'd0);

    directed("xor_zero", 3'd2, 64'd0, 64'd0, 64'd0, 1, 0);
    directed("xor_alt", 3'd2, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, '1, 0, 0);
    directed("and", 3'd0, SA, SB, 64'h020406080A0C0E00, 0, -1);
    directed("or", 3'd1, SA, SB, 64'h1F3F5F7F9FBFDFFF, 0, -1);
    directed("xor", 3'd2, SA, SB, 64'h1D3B597795B3D1FF, 0, -1);
    directed("nor", 3'd3, SA, SB, 64'hE0C0A08060402000, 0, -1);
    directed("nand", 3'd4, SA, SB, 64'hFDFBF9F7F5F3F1FF, 0, -1);
    directed("xnor", 3'd5, SA, SB, 64'hE2C4A6886A4C2E00, 0, -1);
    directed("nota", 3'd6, SA, SB, 64'hEDCBA9876543210F, 0, -1);
    directed("passa", 3'd7, SA, SB, SA, 0, -1);
    directed("self_xor", 3'd2, SX, SX, 64'd0, 1, 0);
    directed("self_xnor", 3'd5, SX, SX, '1, 0, 0);

    // back-to-back stream
    n_out = 0; n_rdy_low = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);
    chk("stream_outputs", 64'(n_out), 64'd8);
    chk("stream_ready_low", 64'(n_rdy_low), 64'd0);

    // backpressure
    n_acc = 0; n_out = 0;
    for (int i = 0; i < 5; i++)
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    chk("bp_accepts", 64'(n_acc), 64'd2);
    chk("bp_ready_low", {63'b0, rdy[0]}, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);
    chk("bp_drained", 64'(n_out), 64'd2);

    // reset with both stages full
    step(1'b1, SA, SB, 3'd1, 1'b0, 1'b0);
    step(1'b1, SB, SA, 3'd2, 1'b0, 1'b0);
    chk("full_before_rst", {63'b0, ovld[0]}, 64'd1);
    step(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1);
    chk("flush_valid", {63'b0, ovld[0]}, 64'd0);
    chk("flush_c", cx[0], 64'd0);
    n_out = 0; n_rdy_low = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);
    chk("flush_no_output", 64'(n_out), 64'd0);
    chk("flush_ready", 64'(n_rdy_low), 64'd0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, {$urandom, $urandom},
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the ALU datapath; it supersedes the fixed 64-bit single-function XOR block.
- Takes two WIDTH-bit operands plus a 3-bit opcode and returns the bitwise result with zero and parity flags.
- It is a 2-stage elastic pipeline with valid/ready handshakes on the input and output sides, so it can sit between the register-read and writeback stages under backpressure.

Parameters:
- WIDTH, 64, operand and result width in bits (min 1).
- OP_W, 3, opcode width (fixed at 3; exposed for package consistency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the operand set on a, b and op is valid.
- in_ready  output  1  the unit accepts the input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  OP_W  opcode (see Behaviour).
- out_valid  output  1  c, zero and parity are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- c  output  WIDTH  result.
- zero  output  1  1 when c == 0.
- parity  output  1  XOR-reduction of c.

Behaviour:
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR, 110 NOT A (b ignored), 111 PASS A (b ignored).
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage 1 (S1): registers a, b and op plus the valid bit s1_v.
- Stage 2 (S2): computes the function from the S1 registers; registers c, zero, parity and s2_v (drives out_valid).
- Advance rules:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = s1_adv (combinational from out_ready and the valid bits; no comb path from in_valid).
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput: 1 op/cycle while out_ready stays high.
- Stall: while out_valid && !out_ready, c, zero and parity hold stable. S1 holds when full. in_ready falls only when both stages are full.
- Simultaneous events: accept and emit in the same cycle is legal. With both stages full and out_ready=1, S2 takes S1 and S1 takes the new input in the same edge. Nothing is lost or duplicated.
- The S2 registers load only on s2_adv && s1_v. When s2_adv && !s1_v, s2_v clears and the data registers keep their old values.
- Reset, at the clock edge with rst=1:
  - s1_v=0, s2_v=0, so out_valid=0.
  - c=0, zero=0, parity=0.
  - S1 data registers clear to 0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation flushes both stages with no output.
- Width rules: all operations are bitwise over WIDTH bits with no carries. zero compares all WIDTH bits. For WIDTH=1, parity equals c.
- Ops are ordered and in-order; the pipeline never reorders.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_NOTA, OP_PASSA.
  - OP_W = 3.
- One sub-module logic_core, purely combinational:
  - Inputs: a, b, op (parameter WIDTH).
  - Outputs: the result, its zero flag and its parity flag.
- logic_unit_pipe holds only the pipeline registers and the handshake logic.

Test Plan:
- Reset, then out_ready=1 and single XOR inputs at WIDTH=64:
  - a=0, b=0 -> c=0, zero=1, parity=0, 2 cycles after transfer.
  - a=AAAA…AA, b=5555…55 -> c=FFFF…FF, zero=0, parity=0.
- Opcode sweep with a=123456789ABCDEF0, b=0F0F0F0F0F0F0F0F -> expected results:
  - AND: 020406080A0C0E00.
  - OR: 1F3F5F7F9FBFDFFF.
  - XOR: 1D3B597795B3D1FF.
  - NOT A: EDCBA9876543210F.
  - PASS A: 123456789ABCDEF0.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, with in_ready never low.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready drops after 2 accepts, and c stays stable.
  - Release out_ready -> the remaining ops drain in order with no loss or duplication.
- Self-XOR with a=b=DEAABEEECAAEBEBE -> c=0, zero=1, parity=0.
  - Same check with XNOR -> c=FFFF…FF, parity=0.
- Assert rst while both stages are full -> out_valid=0 and c=0 next cycle, no stale output afterwards, and in_ready=1.
  - Repeat the full test plan at WIDTH=8 and WIDTH=1.
